// File: rtl/memory_interface_pkg.sv
`default_nettype none
// ============================================================================
// Package  : memory_interface_pkg
// Summary  : Shared request-field layout, block geometry and controller state
//            encoding for the cache <-> memory controller interface.
// Revision : 1.0 - initial release
// ============================================================================
package memory_interface_pkg;

  // Request layout at the default 16-bit address width: {write, data, address}
  localparam int REQUEST_WRITE_BIT   = 24;
  localparam int REQUEST_DATA_MSB    = 23;
  localparam int REQUEST_DATA_LSB    = 16;
  localparam int REQUEST_ADDRESS_MSB = 15;
  localparam int REQUEST_ADDRESS_LSB = 0;

  // A returned block is two bytes: even address in the low byte
  localparam int BLOCK_BYTES = 2;

  // Controller state encoding
  localparam int STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_WRITE   = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_READ_LO = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_LO = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_READ_HI = 3'd4;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_HI = 3'd5;
  localparam logic [STATE_WIDTH-1:0] ST_RESPOND = 3'd6;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = ST_IDLE,
    WRITE   = ST_WRITE,
    READ_LO = ST_READ_LO,
    WAIT_LO = ST_WAIT_LO,
    READ_HI = ST_READ_HI,
    WAIT_HI = ST_WAIT_HI,
    RESPOND = ST_RESPOND
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_model.sv
`default_nettype none
// ============================================================================
// Module   : sram_model
// Summary  : Behavioural byte-wide single-port synchronous SRAM with a
//            READ_LATENCY-deep read pipeline and a backdoor preload port.
// Revision : 1.0 - initial release
// ============================================================================
module sram_model
  #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 1
  ) (
    input  logic                     clock,
    input  logic                     i_enable,
    input  logic                     i_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [7:0]               i_write_data,
    output logic [7:0]               o_read_data,
    input  logic                     i_preload_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_preload_address,
    input  logic [7:0]               i_preload_data
  );

  logic [7:0] r_mem   [2**ADDRESS_WIDTH];
  logic [7:0] r_stage [READ_LATENCY];

  // Array update: the preload backdoor takes priority over a functional write
  always_ff @(posedge clock) begin
    if (i_preload_enable) begin
      r_mem[i_preload_address] <= i_preload_data;
    end else if (i_enable && i_write_enable) begin
      r_mem[i_address] <= i_write_data;
    end
  end

  // Read pipeline: first stage loads on a read strobe, later stages shift every cycle
  always_ff @(posedge clock) begin
    if (i_enable && !i_write_enable) begin
      r_stage[0] <= r_mem[i_address];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_read_data = r_stage[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Summary  : Serves cache block requests from a byte-wide synchronous SRAM.
//            Writes are write-through followed by a readback of the block.
// Revision : 1.0 - initial release
// ============================================================================
module memory_controller
  import memory_interface_pkg::*;
  #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 1
  ) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDRESS_WIDTH+8:0]   memory_request,
    input  logic                       memory_request_ready,
    output logic [8*BLOCK_BYTES-1:0]   memory_response,
    output logic                       memory_response_ready,
    output logic                       memory_busy,
    output logic [ADDRESS_WIDTH-1:0]   sram_address,
    output logic                       sram_enable,
    output logic                       sram_write_enable,
    output logic [7:0]                 sram_write_data,
    input  logic [7:0]                 sram_read_data
  );

  // Field positions track ADDRESS_WIDTH by shifting the default layout
  localparam int c_addr_shift = ADDRESS_WIDTH - (REQUEST_ADDRESS_MSB - REQUEST_ADDRESS_LSB + 1);
  localparam int c_write_bit  = REQUEST_WRITE_BIT + c_addr_shift;
  localparam int c_data_msb   = REQUEST_DATA_MSB + c_addr_shift;
  localparam int c_data_lsb   = REQUEST_DATA_LSB + c_addr_shift;
  localparam logic [2:0] c_latency = 3'(READ_LATENCY);

  state_t                      r_state,            w_next_state;
  logic [ADDRESS_WIDTH-1:0]    r_address,          w_next_address;
  logic [7:0]                  r_data,             w_next_data;
  logic [2:0]                  r_count,            w_next_count;
  logic [8*BLOCK_BYTES-1:0]    r_response,         w_next_response;
  logic                        r_response_ready,   w_next_response_ready;
  logic                        r_busy,             w_next_busy;
  logic [ADDRESS_WIDTH-1:0]    r_sram_address,     w_next_sram_address;
  logic                        r_sram_enable,      w_next_sram_enable;
  logic                        r_sram_write_enable, w_next_sram_write_enable;
  logic [7:0]                  r_sram_write_data,  w_next_sram_write_data;

  // Next state plus the registered outputs that belong to the state being entered
  always_comb begin
    w_next_state             = r_state;
    w_next_address           = r_address;
    w_next_data              = r_data;
    w_next_count             = r_count;
    w_next_response          = r_response;
    w_next_response_ready    = 1'b0;
    w_next_busy              = 1'b0;
    w_next_sram_address      = r_sram_address;
    w_next_sram_enable       = 1'b0;
    w_next_sram_write_enable = 1'b0;
    w_next_sram_write_data   = r_sram_write_data;

    case (r_state)
      IDLE: begin
        if (memory_request_ready) begin
          w_next_address = memory_request[ADDRESS_WIDTH-1:0];
          w_next_data    = memory_request[c_data_msb:c_data_lsb];
          w_next_state   = memory_request[c_write_bit] ? WRITE : READ_LO;
        end
      end
      WRITE:   w_next_state = READ_LO;
      READ_LO: begin
        w_next_state = WAIT_LO;
        w_next_count = c_latency;
      end
      WAIT_LO: begin
        // Capture on the cycle the counter steps down to zero
        w_next_count = r_count - 3'd1;
        if (r_count == 3'd1) begin
          w_next_response[7:0] = sram_read_data;
          w_next_state         = READ_HI;
        end
      end
      READ_HI: begin
        w_next_state = WAIT_HI;
        w_next_count = c_latency;
      end
      WAIT_HI: begin
        w_next_count = r_count - 3'd1;
        if (r_count == 3'd1) begin
          w_next_response[15:8] = sram_read_data;
          w_next_state          = RESPOND;
        end
      end
      RESPOND: begin
        if (!memory_request_ready) begin
          w_next_response = '0;
          w_next_state    = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    case (w_next_state)
      WRITE: begin
        w_next_sram_enable       = 1'b1;
        w_next_sram_write_enable = 1'b1;
        w_next_sram_address      = w_next_address;
        w_next_sram_write_data   = w_next_data;
      end
      READ_LO: begin
        w_next_sram_enable  = 1'b1;
        w_next_sram_address = {w_next_address[ADDRESS_WIDTH-1:1], 1'b0};
      end
      READ_HI: begin
        w_next_sram_enable  = 1'b1;
        w_next_sram_address = {w_next_address[ADDRESS_WIDTH-1:1], 1'b1};
      end
      RESPOND: w_next_response_ready = 1'b1;
      default: ;
    endcase

    w_next_busy = (w_next_state != IDLE);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state             <= IDLE;
      r_address           <= '0;
      r_data              <= '0;
      r_count             <= '0;
      r_response          <= '0;
      r_response_ready    <= 1'b0;
      r_busy              <= 1'b0;
      r_sram_address      <= '0;
      r_sram_enable       <= 1'b0;
      r_sram_write_enable <= 1'b0;
      r_sram_write_data   <= '0;
    end else begin
      r_state             <= w_next_state;
      r_address           <= w_next_address;
      r_data              <= w_next_data;
      r_count             <= w_next_count;
      r_response          <= w_next_response;
      r_response_ready    <= w_next_response_ready;
      r_busy              <= w_next_busy;
      r_sram_address      <= w_next_sram_address;
      r_sram_enable       <= w_next_sram_enable;
      r_sram_write_enable <= w_next_sram_write_enable;
      r_sram_write_data   <= w_next_sram_write_data;
    end
  end

  assign memory_response       = r_response;
  assign memory_response_ready = r_response_ready;
  assign memory_busy           = r_busy;
  assign sram_address          = r_sram_address;
  assign sram_enable           = r_sram_enable;
  assign sram_write_enable     = r_sram_write_enable;
  assign sram_write_data       = r_sram_write_data;

endmodule
`default_nettype wire
